// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and overflow helper for the sequential EX-stage ALU.
// MUL support is controlled by the SEQ_ALU_MUL_EN macro in seq_alu.sv.
package seq_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Two's-complement overflow: operands (B inverted for SUB) agree in sign but the result does not.
  function automatic logic ovf_flag(input logic is_sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    logic b_eff;
    b_eff = b_msb ^ is_sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// The first step is folded into the start cycle so the product is ready WIDTH-1 cycles later.
module seq_alu_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod_lo,
  output logic [WIDTH-1:0] o_prod_hi
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_hi_in;
  logic [WIDTH-1:0] w_lo_in;
  logic [WIDTH:0]   w_sum;
  logic             w_step;
  logic             w_last;

  assign w_a     = i_start ? i_a : r_a;
  assign w_hi_in = i_start ? '0  : r_hi;
  assign w_lo_in = i_start ? i_b : r_lo;
  assign w_sum   = {1'b0, w_hi_in} + (w_lo_in[0] ? {1'b0, w_a} : '0);
  assign w_last  = r_busy && (r_cnt == '0);
  assign w_step  = i_start || (r_busy && !w_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= CW'(WIDTH - 1);
        r_a    <= i_a;
      end else if (w_last) begin
        r_busy <= 1'b0;
      end else if (r_busy) begin
        r_cnt  <= r_cnt - 1'b1;
      end
      // {hi,lo} shifts right; consumed multiplier bits leave lo as product bits enter.
      if (w_step) begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], w_lo_in[WIDTH-1:1]};
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = w_last;
  assign o_prod_lo = r_lo;
  assign o_prod_hi = r_hi;

endmodule

// File: rtl/seq_alu.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift/compare, optional iterative MUL.
// Define SEQ_ALU_MUL_EN to build the multiplier; otherwise code 1010 is reported illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       alu_ctrl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             illegal_o
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;

  logic             w_in_ready;
  logic             w_is_mul;
  logic             w_load_alu;
  logic             w_load_mul;
  logic             w_drain;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic             w_alu_illegal;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH-1:0] w_mul_hi;

  assign w_shamt = src2_i[SHW-1:0];
  assign w_sum   = src1_i + src2_i;
  assign w_diff  = src1_i - src2_i;

  // Over-range shift amounts (non-power-of-2 WIDTH) fall out of the shift operators as 0 / sign fill.
  always_comb begin
    w_alu_res     = '0;
    w_alu_ovf     = 1'b0;
    w_alu_illegal = 1'b0;
    case (alu_ctrl_i)
      ALU_AND:  w_alu_res = src1_i & src2_i;
      ALU_OR:   w_alu_res = src1_i | src2_i;
      ALU_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = ovf_flag(1'b0, src1_i[WIDTH-1], src2_i[WIDTH-1], w_sum[WIDTH-1]);
      end
      ALU_XOR:  w_alu_res = src1_i ^ src2_i;
      ALU_SLL:  w_alu_res = src1_i << w_shamt;
      ALU_SRL:  w_alu_res = src1_i >> w_shamt;
      ALU_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = ovf_flag(1'b1, src1_i[WIDTH-1], src2_i[WIDTH-1], w_diff[WIDTH-1]);
      end
      ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      ALU_SRA:  w_alu_res = $unsigned($signed(src1_i) >>> w_shamt);
      ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      ALU_NOR:  w_alu_res = ~(src1_i | src2_i);
`ifdef SEQ_ALU_MUL_EN
      ALU_MUL:  w_alu_res = '0;
`endif
      default:  w_alu_illegal = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  assign w_is_mul = (alu_ctrl_i == ALU_MUL);

  seq_alu_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_load_mul),
    .i_a       (src1_i),
    .i_b       (src2_i),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_prod_lo (w_mul_lo),
    .o_prod_hi (w_mul_hi)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_busy = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_lo   = '0;
  assign w_mul_hi   = '0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_load_alu   = 1'b0;
    w_load_mul   = 1'b0;
    w_drain      = r_out_valid && out_ready_i;
    case (r_state)
      IDLE: begin
        w_in_ready = !r_out_valid || out_ready_i;
        if (in_valid_i && w_in_ready) begin
          if (w_is_mul) begin
            w_load_mul   = 1'b1;
            w_state_next = MUL;
          end else begin
            w_load_alu   = 1'b1;
          end
        end
      end
      MUL: begin
        if (w_mul_done) begin
          w_state_next = HOLD;
        end else if (!w_mul_busy) begin
          w_state_next = IDLE;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_alu) begin
        r_out_valid <= 1'b1;
        r_result    <= w_alu_illegal ? '0 : w_alu_res;
        r_result_hi <= '0;
        r_zero      <= (src1_i == src2_i);
        r_ovf       <= w_alu_ovf;
        r_illegal   <= w_alu_illegal;
      end else if (w_load_mul) begin
        // Flags are captured now; the product arrives when the multiplier finishes.
        r_out_valid <= 1'b0;
        r_zero      <= (src1_i == src2_i);
        r_ovf       <= 1'b0;
        r_illegal   <= 1'b0;
      end else if (r_state == MUL && w_mul_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_mul_lo;
        r_result_hi <= w_mul_hi;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign result_hi_o = r_result_hi;
  assign zero_o      = r_zero;
  assign ovf_o       = r_ovf;
  assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=16; expectations follow SEQ_ALU_MUL_EN when defined.
module tb_seq_alu;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        zero;
    logic        ovf;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] src1 = '0;
  logic [15:0] src2 = '0;
  logic [3:0]  ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        zero;
  logic        ovf;
  logic        illegal;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  localparam int NOPS = 14;
  localparam logic [3:0]  OP_T [NOPS] = '{4'h2, 4'h6, 4'h7, 4'h9, 4'h8, 4'h4, 4'hD,
                                          4'h0, 4'h1, 4'h3, 4'h5, 4'hC, 4'h6, 4'hE};
  localparam logic [15:0] A_T  [NOPS] = '{16'h7FFF, 16'h0005, 16'hFFFF, 16'hFFFF, 16'h8000,
                                          16'h0001, 16'h1234, 16'hF0F0, 16'hF0F0, 16'hAAAA,
                                          16'h8000, 16'h0F0F, 16'h8000, 16'h0001};
  localparam logic [15:0] B_T  [NOPS] = '{16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'h0004,
                                          16'h000F, 16'h5678, 16'hFF00, 16'h0F0F, 16'hFFFF,
                                          16'h000F, 16'h00F0, 16'h0001, 16'h0001};

`ifdef SEQ_ALU_MUL_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 1;
`endif

  seq_alu #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .src1_i      (src1),
    .src2_i      (src2),
    .alu_ctrl_i  (ctrl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .result_hi_o (result_hi),
    .zero_o      (zero),
    .ovf_o       (ovf),
    .illegal_o   (illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    int     sa;
    int     sb;
    int     s;
    int     amt;
    longint p;
    e      = '0;
    e.zero = (a == b);
    sa     = int'($signed(a));
    sb     = int'($signed(b));
    amt    = int'(b[3:0]);
    p      = 0;
    case (op)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: begin s = sa + sb; e.res = 16'(s); e.ovf = (s > 32767) || (s < -32768); end
      4'h3: e.res = a ^ b;
      4'h4: e.res = 16'(32'(a) << amt);
      4'h5: e.res = 16'(32'(a) >> amt);
      4'h6: begin s = sa - sb; e.res = 16'(s); e.ovf = (s > 32767) || (s < -32768); end
      4'h7: e.res = (sa < sb) ? 16'd1 : 16'd0;
      4'h8: e.res = 16'(sa >>> amt);
      4'h9: e.res = (int'(a) < int'(b)) ? 16'd1 : 16'd0;
`ifdef SEQ_ALU_MUL_EN
      4'hA: begin p = longint'(a) * longint'(b); e.res = p[15:0]; e.hi = p[31:16]; end
`endif
      4'hC: e.res = ~(a | b);
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Output monitor: every completed output handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_output: result=%h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_vec++;
        if (result !== e.res) begin n_err++; $display("FAIL result: got %h want %h", result, e.res); end
        n_vec++;
        if (result_hi !== e.hi) begin n_err++; $display("FAIL result_hi: got %h want %h", result_hi, e.hi); end
        n_vec++;
        if (zero !== e.zero) begin n_err++; $display("FAIL zero: got %b want %b", zero, e.zero); end
        n_vec++;
        if (ovf !== e.ovf) begin n_err++; $display("FAIL ovf: got %b want %b", ovf, e.ovf); end
        n_vec++;
        if (illegal !== e.ill) begin n_err++; $display("FAIL illegal: got %b want %b", illegal, e.ill); end
        $display("txn: result=%h hi=%h zero=%b ovf=%b illegal=%b", result, result_hi, zero, ovf, illegal);
      end
    end
  end

  // Presents one operation, pushes its expectation when accepted; returns at accept edge + 1.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bit ok;
    ok = 1'b0;
    ctrl = op; src1 = a; src2 = b; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(op, a, b));
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready=%b want 1 within 100 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_vec++; if (result !== 16'h0) begin n_err++; $display("FAIL rst_result: got %h want 0000", result); end
    n_vec++; if (result_hi !== 16'h0) begin n_err++; $display("FAIL rst_result_hi: got %h want 0000", result_hi); end
    n_vec++; if ({zero, ovf, illegal} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {zero, ovf, illegal}); end
    $display("txn: reset released");
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    out_ready = 1'b1;
    for (int i = 0; i < NOPS; i++) begin
      send(OP_T[i], A_T[i], B_T[i]);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL op_latency op=%h: out_valid=%b want 1 one cycle after accept", OP_T[i], out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    int k;
    out_ready = 1'b1;
    send(4'hA, 16'hFFFF, 16'hFFFF);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1 && MUL_LAT > 1) begin
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL mul_busy_ready: in_ready=%b want 0", in_ready); end
      end
      if (out_valid) break;
    end
    n_vec++;
    if (k != MUL_LAT) begin n_err++; $display("FAIL mul_latency: got %0d want %0d", k, MUL_LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ctrl = 4'h2; src1 = 16'(i * 16'h1111); src2 = 16'(i + 1);
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      else sb_q.push_back(model(4'h2, src1, src2));
      if (i > 0) begin
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[8]: got %b want 1", out_valid); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(4'h2, 16'h1234, 16'h0101);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", c, out_valid); end
      n_vec++; if (result !== 16'h1335) begin n_err++; $display("FAIL stall_result[%0d]: got %h want 1335", c, result); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", c, in_ready); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    send(4'hA, 16'h0003, 16'h0005);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    $display("txn: reset during multiply");
    @(posedge clk); #1;
    send(4'h2, 16'h0100, 16'h0023);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_add_valid: got %b want 1", out_valid); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ops();
    test_mul();
    test_back_to_back();
    test_stall();
    test_reset_mid_mul();
    repeat (2) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d left want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
